// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised Fibonacci LFSR with reseed handshake, wrap pulse
// and optional period measurement (built when LFSR_GEN_PERIOD_EN is defined).
// Ports: clk, rst (sync, active-high), en, load_valid/load_data/load_ready,
//        load_err, lfsr (state), wrap, period.
module lfsr_gen #(
  parameter int              WIDTH = 5,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(5'b00101),
  parameter logic [WIDTH-1:0] SEED = '1,
  parameter int              STEP  = 1,
  parameter int              CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             load_err,
  output logic [WIDTH-1:0] lfsr,
  output logic             wrap,
  output logic [CNT_W-1:0] period
);

  logic [WIDTH-1:0] start;
  logic [WIDTH-1:0] stepped;
  logic [WIDTH-1:0] load_val;
  logic             load_zero;
  logic             accept;
  logic             hit;

  // STEP single shifts unrolled into one combinational stage
  always_comb begin
    stepped = lfsr;
    for (int i = 0; i < STEP; i++) begin
      stepped = {^(stepped & TAPS), stepped[WIDTH-1:1]};
    end
  end

  assign load_zero = (load_data == '0);
  assign load_val  = load_zero ? SEED : load_data;
  assign accept    = load_valid && load_ready;
  assign hit       = !accept && en && (stepped == start);

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr       <= SEED;
      start      <= SEED;
      wrap       <= 1'b0;
      load_err   <= 1'b0;
      load_ready <= 1'b0;
    end else begin
      // one dead cycle after every accepted load
      load_ready <= !accept;
      wrap       <= hit;
      load_err   <= accept && load_zero;
      if (accept) begin
        lfsr  <= load_val;
        start <= load_val;
      end else if (en) begin
        lfsr <= stepped;
      end
    end
  end

`ifdef LFSR_GEN_PERIOD_EN
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  // saturating increment; a saturated wrap latches all ones
  assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      period <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if (en) begin
      if (hit) begin
        period <= cnt_inc;
        cnt    <= '0;
      end else begin
        cnt <= cnt_inc;
      end
    end
  end
`else
  assign period = '0;
`endif

endmodule

// File: doc/lfsr_gen.md
# lfsr_gen

Parametrised Fibonacci LFSR generator, successor to the fixed 5-bit LFSR used as the pseudo-random source for the DDS/NIOS datapath. It adds configurable width, tap mask, seed and bits-per-cycle stepping. A load handshake allows runtime reseeding with all-zero protection. Sequence wrap detection can optionally measure the period. It sits in the `clk` domain. Its state output feeds DDS dither/noise logic and a CPU-readable status register.

## Interface
Parameters:
- `WIDTH`, default 5: LFSR state width; legal range 3..32.
- `TAPS`, default 5'b00101: feedback mask, where feedback = XOR of `state[i]` for every set bit `i`; must be nonzero.
- `SEED`, default all ones: reset/fallback state; must be nonzero.
- `STEP`, default 1: single-bit shifts applied per enabled cycle; legal range 1..`WIDTH`.
- `CNT_W`, default 32: period counter width.

Ports:
- `clk` in 1: clock. One clock; everything is in this domain.
- `rst` in 1: reset. Synchronous, active-high.
- `en` in 1: advance enable.
- `load_valid` in 1: reseed request.
- `load_data` in `WIDTH`: reseed value.
- `load_ready` out 1: reseed accepted when `load_valid && load_ready`.
- `load_err` out 1: one-cycle pulse, asserted when a zero reseed value is replaced by `SEED`.
- `lfsr` out `WIDTH`: current state, registered.
- `wrap` out 1: one-cycle pulse, asserted when the state returns to the start value.
- `period` out `CNT_W`: number of enabled cycles in the last completed cycle of the sequence.

## Operation
- Single shift: `fb = ^(state & TAPS)`; `next = {fb, state[WIDTH-1:1]}`.
- Default parameters reproduce the legacy 5-bit LFSR exactly.
- An enabled cycle applies `STEP` single shifts, unrolled combinationally. `lfsr` updates once per cycle.
- Start register `start`:
  - Set to `SEED` on reset.
  - Set to the accepted load value on a load; this is `SEED` if the load value was zero.
- Load acceptance: `lfsr` and `start` take `load_data`, or `SEED` if `load_data == 0`.
  - A zero load value additionally pulses `load_err`.
  - The step counter clears to 0 and `period` is held.
- Load and `en` asserted in the same cycle: the load wins and no step occurs.
- Enabled step without a load:
  - Counter increments by 1.
  - If the post-step state equals `start`: pulse `wrap`, latch `period` = counter + 1, clear the counter.
- Counter saturates at all ones. If saturated at wrap, `period` latches all ones.
- `en` low: state, counter and flags hold. `wrap` and `load_err` are 0.
- `load_ready` deasserts for exactly one cycle after each accepted load, so the earliest back-to-back load is every other cycle.

## Timing
- All outputs are registered. Output changes appear on the `clk` edge after the causing input.
- Reset values, while `rst` is high and on the cycle `rst` is sampled:
  - `lfsr` = `SEED`; `start` = `SEED`; counter = 0.
  - `period` = 0; `wrap` = 0; `load_err` = 0; `load_ready` = 0.
- `load_ready` rises on the first edge with `rst` low.
- Step latency is 1 cycle from `en` sampled high.
- Load latency is 1 cycle. `load_ready` is 0 for the following cycle and 1 again after that.
- Reset mid-sequence or mid-handshake: state returns to `SEED`, and any concurrent load is discarded.
- An all-zero state is unreachable, since load and seed are both guarded.

## Configuration
- `LFSR_GEN_PERIOD_EN` defined: counter, `period` latch and saturation logic are built as described.
- `LFSR_GEN_PERIOD_EN` undefined:
  - Counter and latch are removed, and `period` is tied to 0.
  - `wrap` detection and all other behaviour are unchanged.

## Test plan
- Sequence check: defaults, release reset, hold `en`=1. `lfsr` must read 11111, 01111, 00111, 00011, 10001, 11000 on successive cycles.
- Period check: defaults, `en`=1 continuously. `wrap` pulses 31 cycles after reset release, `period`=31, and `lfsr`=11111 on the same cycle.
- Multi-step: `STEP`=2, defaults otherwise, one enabled cycle from reset gives `lfsr`=00111.
- Zero reseed: load `load_data`=0. Next cycle `lfsr`=11111, `load_err`=1 for one cycle, and `load_ready`=0 for one cycle.
- Load versus enable collision: in the same cycle, load 5'b10101 with `en`=1. `lfsr`=10101 with no step applied; after 31 further enabled cycles, `wrap`=1 and `period`=31.
- Reset mid-run: assert `rst` after 10 steps. `lfsr`=11111, counter=0, `period`=0, `load_ready`=0 on that cycle; sequence restarts per the first scenario.
